// File: rtl/digitube_scan_driver.sv
// digitube_scan_driver: double-buffered 4-digit 7-segment scan driver with anti-ghosting blanking window.
module digitube_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [11:0] digi_out,
  output logic        frame_done
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BC = CW'(BLANK_CYCLES);
  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   shadow_q, shadow_d, disp_q, disp_d;
  logic [11:0]   digi_q, digi_d;
  logic          frame_done_q, frame_done_d;
  logic          wrap, boundary;
  logic [15:0]   hex_v;
  logic [3:0]    nib, dp_v, bl_v;
  always_comb begin
    wrap = cnt_q == LAST;
    boundary = wrap && idx_q == 2'd3;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q + {1'b0, wrap};
    shadow_d = load ? {blank_in, dp_in, hex_in} : shadow_q;
    // disp takes the pre-edge shadow, so a boundary-cycle load waits a frame
    disp_d = boundary ? shadow_q : disp_q;
    hex_v = disp_q[15:0];
    dp_v = disp_q[19:16];
    bl_v = disp_q[23:20];
    nib = hex_v[{idx_q, 2'b00} +: 4];
    digi_d = (cnt_q < BC) ? 12'h0FF
           : {4'b0001 << idx_q, bl_v[idx_q] ? 8'hFF : {~dp_v[idx_q], SEG[nib]}};
    frame_done_d = boundary;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      shadow_q <= '0;
      disp_q <= '0;
      digi_q <= 12'h0FF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shadow_q <= shadow_d;
      disp_q <= disp_d;
      digi_q <= digi_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign digi_out = digi_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_digitube_scan_driver.sv
// tb_digitube_scan_driver: cycle-by-cycle check of the scan driver against a frame-level model.
module tb_digitube_scan_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [11:0] digi_out;
  logic        frame_done;
  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  int lt[$];
  logic [23:0] lv[$];
  logic [11:0] exp_digi;
  logic        exp_fd;

  digitube_scan_driver #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .digi_out(digi_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // data shown in frame f: last load strictly before the cycle that closes frame f-1
  function automatic logic [23:0] frame_data(input int f);
    logic [23:0] v = '0;
    for (int i = 0; i < lt.size(); i++)
      if (lt[i] <= 16 * f - 2) v = lv[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0d got %h want %h", name, t, got, want);
    end
  endtask

  task automatic tick(input logic r, input logic ld, input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    logic [23:0] v;
    int dig;
    reset = r; load = ld; hex_in = h; dp_in = d; blank_in = b;
    if (r) begin
      exp_digi = 12'h0FF;
      exp_fd = 1'b0;
      t = 0;
      lt.delete();
      lv.delete();
    end else begin
      v = frame_data(t / 16);
      dig = (t / 4) % 4;
      if (t % 4 == 0) exp_digi = 12'h0FF;
      else if (v[20 + dig]) exp_digi = {4'(1 << dig), 8'hFF};
      else exp_digi = {4'(1 << dig), ~v[16 + dig], seg7(v[4 * dig +: 4])};
      exp_fd = (t % 16 == 15);
      if (ld) begin
        lt.push_back(t);
        lv.push_back({b, d, h});
      end
      t++;
    end
    @(negedge clk);
    chk("digi_out", digi_out, exp_digi);
    chk("frame_done", {11'b0, frame_done}, {11'b0, exp_fd});
  endtask

  task automatic run_to(input int n);
    while (t < n) tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) tick(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0);
    chk("rst_digi", digi_out, 12'h0FF);
    chk("rst_fd", {11'b0, frame_done}, 12'h000);
    run_to(2);
    chk("first_frame_d0", digi_out, 12'b0001_1_1000000);
    run_to(5);
    tick(1'b0, 1'b1, 16'h1A2F, 4'b0010, 4'b0000);
    run_to(16);
    chk("frame_done_pulse", {11'b0, frame_done}, 12'h001);
    run_to(18);
    chk("d0_F", digi_out, 12'b0001_1_0001110);
    run_to(22);
    chk("d1_2_dp", digi_out, 12'b0010_0_0100100);
    run_to(26);
    chk("d2_A", digi_out, 12'b0100_1_0001000);
    run_to(30);
    chk("d3_1", digi_out, 12'b1000_1_1111001);
    run_to(31);
    tick(1'b0, 1'b1, 16'h4321, 4'b0000, 4'b0000);
    run_to(34);
    chk("tear_old", digi_out, 12'b0001_1_0001110);
    run_to(50);
    chk("tear_new", digi_out, 12'b0001_1_1111001);
    tick(1'b0, 1'b1, 16'h8888, 4'b0000, 4'b0000);
    run_to(62);
    chk("midframe_hold", digi_out, 12'b1000_1_0011001);
    run_to(66);
    chk("midframe_next", digi_out, 12'b0001_1_0000000);
    tick(1'b0, 1'b1, 16'h9876, 4'b1111, 4'b0101);
    run_to(82);
    chk("blank_d0", digi_out, 12'h1FF);
    run_to(86);
    chk("blank_d1", digi_out, 12'b0010_0_1111000);
    run_to(90);
    chk("blank_d2", digi_out, 12'h4FF);
    run_to(94);
    chk("blank_d3", digi_out, 12'b1000_0_0010000);
    run_to(106);
    repeat (3) tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    chk("midslot_rst", digi_out, 12'h0FF);
    run_to(1);
    chk("restart_blank", digi_out, 12'h0FF);
    run_to(2);
    chk("restart_d0", digi_out, 12'b0001_1_1000000);
    run_to(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/digitube_scan_driver.md
# digitube_scan_driver

Time-multiplexing driver for the 4-digit 7-segment display. It takes four hex nibbles plus per-digit decimal-point and blank flags, and produces the 12-bit scanning digit bus {AN3,AN2,AN1,AN0,DP,CG,CF,CE,CD,CC,CB,CA}. That bus is the same format the board-side de-scanning adapter consumes. The block sits between the CPU's display peripheral register and the board pins. It includes a tear-free double buffer, a programmable scan rate and an anti-ghosting blanking window.

## Interface
Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range is 2 or more.
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; legal range is 0 to SCAN_DIV-1.

Ports:
- clk  input  1  system clock; the block uses this single clock only.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures hex_in, dp_in and blank_in into the shadow register.
- hex_in  input  16  digit n value is hex_in[4n+3:4n].
- dp_in  input  4  decimal point for digit n; 1 means lit.
- blank_in  input  4  when 1, digit n shows nothing (segments and DP off).
- digi_out  output  12  registered scan bus: [11:8] anodes, active-high one-hot (bit 8 = digit 0); [7] DP, active-low; [6:0] CG..CA, active-low.
- frame_done  output  1  one-cycle pulse after digit 3's slot ends.

## Operation
- Registers:
  - Prescaler cnt counts 0..SCAN_DIV-1; width is clog2(SCAN_DIV).
  - Digit index idx is 2 bits.
  - Shadow register: 24 bits.
  - Display register disp: 24 bits.
- cnt increments every cycle and wraps at SCAN_DIV-1. idx increments on that wrap, cycling 0→1→2→3→0.
- load=1 sets shadow ← {blank_in, dp_in, hex_in}.
- Frame boundary: idx==3 and cnt==SCAN_DIV-1. On that cycle disp ← shadow, which holds the shadow value from before this edge.
  - If load is also asserted on the boundary cycle, the new data reaches shadow only and is displayed one frame later.
- Output register, evaluated every cycle from the current (idx, cnt, disp):
  - If cnt < BLANK_CYCLES: digi_out = 12'b0000_1111_1111.
  - Otherwise the anode field is onehot(idx).
    - If blank[idx]=1: DP=1 and segments = 7'b1111111.
    - If blank[idx]=0: DP = ~dp[idx] and segments = decode(hex[idx]).
- Decode, as CG..CA active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- frame_done is a registered pulse, high for the one cycle following each frame-boundary cycle.
- Reset, synchronous and dominant over load:
  - cnt=0, idx=0, shadow=0, disp=0.
  - digi_out = 12'b0000_1111_1111, frame_done=0.
  - Reset asserted mid-slot or mid-frame aborts the scan. The scan restarts at digit 0, cnt 0 on the first cycle after reset deasserts.

## Timing
- digi_out lags its (idx, cnt) state by exactly one clock.
- Each digit slot is SCAN_DIV cycles long:
  - BLANK_CYCLES cycles with anodes off,
  - then SCAN_DIV-BLANK_CYCLES cycles with the digit lit.
- A frame is 4·SCAN_DIV cycles. Exactly one anode bit is ever high at a time, and never during the blanking window.
- Latency from load to the data being visible:
  - minimum: next frame boundary + 1 cycle;
  - maximum: 4·SCAN_DIV + 1 cycles.
- Displayed data never changes within a frame; this is the tear-free requirement.
- BLANK_CYCLES=0: no blanking; an anode is driven on every cycle.
- The first frame after reset shows disp=0. That is all digits "0" unblanked, DP off, segments 1000000.

## Test plan
Unless noted, all tests use SCAN_DIV=4 and BLANK_CYCLES=1.
- Reset check: hold reset for 3 cycles with load=1 and hex_in=16'hFFFF.
  - Expect digi_out=12'h0FF and frame_done=0 throughout.
  - Expect shadow to stay 0, so the first frame shows "0000" and digit 0 reads 12'b0001_1_1000000.
- Load 16'h1A2F, dp_in=4'b0010, blank_in=0 at cycle 5, then run 2 frames.
  - Frame 2, digit 0 window: 12'b0001_1_0001110.
  - Digit 1: 12'b0010_0_0100100 (DP lit).
  - Digit 2: 12'b0100_1_0001000.
  - Digit 3: 12'b1000_1_1111001.
- Scan timing: confirm each slot shows 1 cycle of 12'h0FF followed by 3 lit cycles.
  - Anodes step 0001→0010→0100→1000→0001.
  - frame_done pulses once every 16 cycles.
- Tear test with a load exactly on the frame-boundary cycle.
  - The following frame still shows the old data.
  - The frame after that shows the new data.
  - A load mid-frame never changes digits later in that same frame.
- blank_in=4'b0101 with dp_in=4'b1111: digits 0 and 2 drive their anode with DP and segments off (low byte 8'hFF); digits 1 and 3 show DP lit.
- Reset asserted mid-slot at idx=2, cnt=2, then deasserted.
  - Output is 12'h0FF during reset.
  - After release the scan resumes at digit 0 with a full blanking window.
  - The displayed value is 0.
